// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the one-hot round-robin arbiter.
package arb_pkg;

    localparam int NREQ  = 16;
    localparam int PTR_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // Rotate pointer to the slot after the winner; PTR_W bits wrap 15 -> 0.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return idx + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping to 0.
module rr_pick import arb_pkg::*; (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_pick,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from farthest to nearest so the last hit is the closest to i_ptr.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (i_req[i_ptr + PTR_W'(i)]) begin
                o_idx = i_ptr + PTR_W'(i);
                o_any = 1'b1;
            end
        end
        o_pick = o_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with IDLE/GRANT/BUSY handshake and per-grant hold cap.
// Define ARB_LOCK_EN to add a lock input that holds a grant past HOLD_MAX.
module onehot_rr_arbiter #(
    parameter int NREQ     = arb_pkg::NREQ,
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt_onehot,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    output logic            enc_en,
    output logic            busy
`ifdef ARB_LOCK_EN
    ,
    input  logic            lock
`endif
);
    import arb_pkg::*;

    generate
        if (NREQ != 16 || HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_cfg
            $error("onehot_rr_arbiter: NREQ must be 16 and HOLD_MAX in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(HOLD_MAX - 1);

    arb_state_e       r_state,  w_state_nxt;
    logic [NREQ-1:0]  r_gnt,    w_gnt_nxt;
    logic             r_vld,    w_vld_nxt;
    logic             r_enc,    w_enc_nxt;
    logic             r_busy,   w_busy_nxt;
    logic [PTR_W-1:0] r_ptr,    w_ptr_nxt;
    logic [PTR_W-1:0] r_idx,    w_idx_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;

    logic [NREQ-1:0]  w_pick;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_any;
    logic             w_lock;
    logic             w_exit;

`ifdef ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    rr_pick u_pick (
        .i_req  (req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_any)
    );

    // Winner dropping and hold expiry landing together still give one exit.
    assign w_exit = !req[r_idx] || (!w_lock && (r_cnt >= CNT_TERM));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_vld_nxt   = r_vld;
        w_enc_nxt   = r_enc;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt  = '0;
                w_vld_nxt  = 1'b0;
                w_enc_nxt  = 1'b0;
                w_busy_nxt = 1'b0;
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_idx_nxt   = w_pick_idx;
                    w_vld_nxt   = 1'b1;
                    w_enc_nxt   = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (gnt_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_exit) begin
                    w_ptr_nxt   = ptr_after(r_idx);
                    w_gnt_nxt   = '0;
                    w_enc_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_vld_nxt   = 1'b0;
                w_enc_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
            r_enc   <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_vld   <= w_vld_nxt;
            r_enc   <= w_enc_nxt;
            r_busy  <= w_busy_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt_onehot = r_gnt;
    assign gnt_valid  = r_vld;
    assign enc_en     = r_enc;
    assign busy       = r_busy;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench: per-cycle reference model plus directed literal checks.
module tb_onehot_rr_arbiter;

    localparam int HOLD_MAX = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt_onehot;
    logic        gnt_valid;
    logic        gnt_ready;
    logic        enc_en;
    logic        busy;
    logic        lock;

    int n_cmp = 0;
    int n_err = 0;

    onehot_rr_arbiter #(.NREQ(16), .HOLD_MAX(HOLD_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_onehot (gnt_onehot),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .enc_en     (enc_en),
        .busy       (busy)
`ifdef ARB_LOCK_EN
        ,
        .lock       (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: mode 0 = idle, 1 = grant offered, 2 = grant held.
    int m_mode = 0;
    int m_ptr  = 0;
    int m_win  = 0;
    int m_held = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_ptr = 0; m_win = 0; m_held = 0;
        end else begin
            case (m_mode)
                0: begin
                    bit found;
                    found = 1'b0;
                    for (int k = 0; k < 16; k++) begin
                        if (!found && req[(m_ptr + k) % 16]) begin
                            found  = 1'b1;
                            m_win  = (m_ptr + k) % 16;
                            m_mode = 1;
                        end
                    end
                end
                1: if (gnt_ready) begin m_mode = 2; m_held = 0; end
                default: begin
                    m_held++;
                    if (!req[m_win] || (m_held >= HOLD_MAX && !lock)) begin
                        m_mode = 0;
                        m_ptr  = (m_win + 1) % 16;
                    end
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_gnt",   {16'h0, gnt_onehot}, (m_mode != 0) ? (32'h1 << m_win) : 32'h0);
        chk("cyc_valid", {31'h0, gnt_valid},  {31'h0, m_mode == 1});
        chk("cyc_enc",   {31'h0, enc_en},     {31'h0, m_mode != 0});
        chk("cyc_busy",  {31'h0, busy},       {31'h0, m_mode == 2});
        chk("cyc_onehot", {31'h0, $countones(gnt_onehot) <= 1}, 32'h1);
    end

    // Observed grant sequence and BUSY run lengths, checked against literals.
    logic [15:0] gq[$];
    int          bq[$];
    logic        mon_pv = 1'b0;
    int          run = 0;

    always @(negedge clk) begin
        if (gnt_valid === 1'b1 && !mon_pv) gq.push_back(gnt_onehot);
        mon_pv = (gnt_valid === 1'b1);
        if (busy === 1'b1) run++;
        else if (run > 0) begin bq.push_back(run); run = 0; end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0; req = '0; gnt_ready = 1'b0; lock = 1'b0;
        tick(3);
        chk("rst_gnt",   {16'h0, gnt_onehot}, 32'h0);
        chk("rst_valid", {31'h0, gnt_valid},  32'h0);
        chk("rst_enc",   {31'h0, enc_en},     32'h0);
        chk("rst_busy",  {31'h0, busy},       32'h0);
        rst_n = 1'b1;

        // First grant one cycle after request, ready accepted next cycle.
        req = 16'h0001; gnt_ready = 1'b1;
        tick(1);
        chk("first_gnt",   {16'h0, gnt_onehot}, 32'h0001);
        chk("first_valid", {31'h0, gnt_valid},  32'h1);
        chk("first_enc",   {31'h0, enc_en},     32'h1);
        req = 16'h0;
        tick(1);
        chk("first_busy",  {31'h0, busy},       32'h1);
        chk("first_vdrop", {31'h0, gnt_valid},  32'h0);
        tick(1);
        chk("first_release", {16'h0, gnt_onehot}, 32'h0);

        // Grant held stable without ready; ptr is 1 so bit 2 wins over bit 5.
        req = 16'h0024; gnt_ready = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_gnt",   {16'h0, gnt_onehot}, 32'h0004);
            chk("stall_valid", {31'h0, gnt_valid},  32'h1);
            tick(1);
        end
        gnt_ready = 1'b1;
        tick(1);
        chk("stall_busy", {31'h0, busy}, 32'h1);
        req = 16'h0;
        tick(2);

        // All requesting: strict rotation, each BUSY exactly HOLD_MAX cycles.
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        gq.delete(); bq.delete();
        req = 16'hFFFF;
        t = 0;
        while (gq.size() < 17 && t < 400) begin tick(1); t++; end
        chk("rot_timeout", {31'h0, gq.size() >= 17}, 32'h1);
        req = 16'h0;
        tick(12);
        for (int i = 0; i < 17; i++)
            chk("rot_order", {16'h0, (i < gq.size()) ? gq[i] : 16'h0},
                (i == 16) ? 32'h1 : (32'h1 << i));
        for (int i = 0; i < 16; i++)
            chk("rot_hold", (i < bq.size()) ? bq[i] : -1, 8);

        // Wrap: winner 14 leaves ptr at 15, then 15 beats 0, then 0.
        gq.delete(); bq.delete();
        req = 16'h4000;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin tick(1); t++; end
        chk("wrap_busy_wait", {31'h0, busy}, 32'h1);
        req = 16'h8001;
        t = 0;
        while (gq.size() < 3 && t < 100) begin tick(1); t++; end
        req = 16'h0;
        tick(12);
        chk("wrap_g0", {16'h0, (gq.size() > 0) ? gq[0] : 16'h0}, 32'h4000);
        chk("wrap_g1", {16'h0, (gq.size() > 1) ? gq[1] : 16'h0}, 32'h8000);
        chk("wrap_g2", {16'h0, (gq.size() > 2) ? gq[2] : 16'h0}, 32'h0001);

        // Reset during BUSY drops everything; next grant restarts from index 0.
        req = 16'h0100;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin tick(1); t++; end
        chk("rbusy_gnt", {16'h0, gnt_onehot}, 32'h0100);
        rst_n = 1'b0; req = 16'h0101;
        tick(1);
        chk("rbusy_gnt0",   {16'h0, gnt_onehot}, 32'h0);
        chk("rbusy_valid0", {31'h0, gnt_valid},  32'h0);
        chk("rbusy_enc0",   {31'h0, enc_en},     32'h0);
        chk("rbusy_busy0",  {31'h0, busy},       32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("rbusy_regrant", {16'h0, gnt_onehot}, 32'h0001);
        req = 16'h0;
        tick(12);

        // Non-winner churn ignored; winner drop coinciding with expiry exits once.
        gq.delete(); bq.delete();
        req = 16'h0003;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin tick(1); t++; end
        chk("churn_gnt", {16'h0, gnt_onehot}, 32'h0002);
        req = 16'h00F2;
        tick(7);
        req = 16'h00F1;
        tick(1);
        chk("churn_exit", {31'h0, busy}, 32'h0);
        tick(1);
        chk("churn_next", {16'h0, gnt_onehot}, 32'h0010);
        req = 16'h0;
        tick(12);
        chk("churn_hold", (bq.size() > 0) ? bq[0] : -1, 8);

`ifdef ARB_LOCK_EN
        gq.delete(); bq.delete();
        lock = 1'b1; req = 16'h0010;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin tick(1); t++; end
        tick(19);
        req = 16'h0;
        tick(12);
        chk("lock_len",    (bq.size() > 0) ? bq[0] : -1, 20);
        chk("lock_grants", gq.size(), 1);
        lock = 1'b0;
        gq.delete(); bq.delete();
        req = 16'h0010;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin tick(1); t++; end
        tick(20);
        req = 16'h0;
        tick(12);
        chk("unlock_len", (bq.size() > 0) ? bq[0] : -1, 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
